// File: rtl/rs_stream_encoder.sv
// Streaming systematic Reed-Solomon encoder: message beats pass through, then
// RS_PAR_LEN parity symbols follow, ENC_SYM_NUM symbols per beat.
module rs_stream_encoder #(
    parameter int EGF_ORDER      = 8,
    parameter int EGF_PRIM_POLY  = 'h11D,
    parameter int RS_COD_LEN     = 255,
    parameter int RS_PAR_LEN     = 16,
    parameter int ENC_SYM_NUM    = 4,
    parameter int GEN_FIRST_ROOT = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ENC_SYM_NUM*EGF_ORDER-1:0]   in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ENC_SYM_NUM*EGF_ORDER-1:0]   out_data,
    output logic                               out_parity,
    output logic                               out_last,
    output logic                               err_len
);

    localparam int M         = EGF_ORDER;
    localparam int P         = RS_PAR_LEN;
    localparam int N         = ENC_SYM_NUM;
    localparam int W         = N * M;
    localparam int PW        = P * M;
    localparam int MAX_BEATS = (RS_COD_LEN - RS_PAR_LEN) / ENC_SYM_NUM;
    localparam int PAR_BEATS = RS_PAR_LEN / ENC_SYM_NUM;
    localparam int CNT_MAX   = (MAX_BEATS > PAR_BEATS) ? MAX_BEATS : PAR_BEATS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [M-1:0]     POLY_LO  = M'(EGF_PRIM_POLY);
    localparam logic [CNT_W-1:0] LAST_MSG = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_PAR = CNT_W'(PAR_BEATS - 1);

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[M-1] ? ({sh[M-2:0], 1'b0} ^ POLY_LO) : {sh[M-2:0], 1'b0};
        end
        return acc;
    endfunction

    // Product of (x + alpha^r) over all generator roots; coefficient j at slice j.
    function automatic logic [(P+1)*M-1:0] gen_poly();
        logic [(P+1)*M-1:0] g;
        logic [M-1:0]       root;
        g       = '0;
        g[M-1:0] = M'(1);
        root    = M'(1);
        for (int unsigned k = 0; k < GEN_FIRST_ROOT; k++) root = gf_mul(root, M'(2));
        for (int unsigned i = 0; i < P; i++) begin
            for (int unsigned j = P; j > 0; j--)
                g[j*M +: M] = g[(j-1)*M +: M] ^ gf_mul(g[j*M +: M], root);
            g[0 +: M] = gf_mul(g[0 +: M], root);
            root = gf_mul(root, M'(2));
        end
        return g;
    endfunction

    localparam logic [(P+1)*M-1:0] GEN = gen_poly();

    function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0] p, input logic [M-1:0] sym);
        logic [M-1:0]  fb;
        logic [PW-1:0] r;
        fb = sym ^ p[(P-1)*M +: M];
        r  = p << M;
        for (int unsigned i = 0; i < P; i++)
            r[i*M +: M] = r[i*M +: M] ^ gf_mul(fb, GEN[i*M +: M]);
        return r;
    endfunction

    typedef enum logic {S_MSG, S_PAR} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    par_q;
    logic [PW-1:0]    par_msg_d;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic             out_parity_q;
    logic             out_last_q;
    logic             err_len_q;
    logic             slot_free;

    always_comb begin
        slot_free = !out_valid_q || out_ready;
        in_ready  = (state_q == S_MSG) && slot_free;
        par_msg_d = par_q;
        for (int unsigned l = 0; l < N; l++)
            par_msg_d = lfsr_step(par_msg_d, in_data[(N-1-l)*M +: M]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_MSG;
            cnt_q        <= '0;
            par_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            err_len_q <= 1'b0;
            if (slot_free) begin
                case (state_q)
                    S_MSG: begin
                        out_valid_q <= in_valid;
                        if (in_valid) begin
                            out_data_q   <= in_data;
                            out_parity_q <= 1'b0;
                            out_last_q   <= 1'b0;
                            par_q        <= par_msg_d;
                            if (in_last || cnt_q == LAST_MSG) begin
                                err_len_q <= !in_last;
                                state_q   <= S_PAR;
                                cnt_q     <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    S_PAR: begin
                        // Draining the register empties it, ready for the next codeword.
                        out_valid_q  <= 1'b1;
                        out_data_q   <= par_q[PW-1 -: W];
                        par_q        <= par_q << W;
                        out_parity_q <= 1'b1;
                        out_last_q   <= (cnt_q == LAST_PAR);
                        if (cnt_q == LAST_PAR) begin
                            state_q <= S_MSG;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;
    assign out_last   = out_last_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Directed bench for rs_stream_encoder in the GF(16), RS(15,11), 2-symbol-per-beat configuration.
module tb_rs_stream_encoder;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_last;
    logic       out_valid, out_ready, out_parity, out_last, err_len;
    logic [7:0] in_data, out_data;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         err_pulses = 0;
    int         err_idx    = 0;
    int         span;
    bit         rand_rdy = 1'b0;
    logic       hold_valid = 1'b0;
    logic [9:0] held;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int         got_cyc[$];

    rs_stream_encoder #(
        .EGF_ORDER     (4),
        .EGF_PRIM_POLY ('h13),
        .RS_COD_LEN    (15),
        .RS_PAR_LEN    (4),
        .ENC_SYM_NUM   (2),
        .GEN_FIRST_ROOT(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_parity(out_parity),
        .out_last  (out_last),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    endtask

    // Output monitor: collects accepted beats, checks stability under stall, notes err_len.
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid)
                check("stall_hold", 32'({out_valid, out_data, out_parity, out_last}), 32'({1'b1, held}));
            if (err_len) begin
                err_pulses++;
                err_idx = got_q.size();
            end
            if (out_valid && out_ready) begin
                got_q.push_back({out_data, out_parity, out_last});
                got_cyc.push_back(cyc);
                hold_valid = 1'b0;
            end else if (out_valid) begin
                hold_valid = 1'b1;
                held = {out_data, out_parity, out_last};
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        in_data  = 8'hA5;
        in_last  = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic l);
        exp_q.push_back({d, p, l});
    endtask

    task automatic send_unit();
        send_beat(8'h00, 1'b0);
        send_beat(8'h01, 1'b1);
    endtask

    task automatic exp_unit();
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'h01, 1'b0, 1'b0);
        push_exp(8'hDC, 1'b1, 1'b0);
        push_exp(8'h87, 1'b1, 1'b1);
    endtask

    task automatic drain(input int n);
        int k = 0;
        while (got_q.size() < n && k < 300) begin
            tick();
            k++;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'(0));
        check("rst_out_data",   32'(out_data),   32'(0));
        check("rst_out_parity", 32'(out_parity), 32'(0));
        check("rst_out_last",   32'(out_last),   32'(0));
        check("rst_err_len",    32'(err_len),    32'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        tick();

        // A: all-zero, full length, in_last on the final allowed beat
        for (int i = 0; i < 5; i++) begin
            send_beat(8'h00, 1'(i == 4));
            push_exp(8'h00, 1'b0, 1'b0);
        end
        push_exp(8'h00, 1'b1, 1'b0);
        push_exp(8'h00, 1'b1, 1'b1);
        drain(7);
        compare("A");
        check("A_no_err", 32'(err_pulses), 32'(0));

        // B: unit message
        send_unit();
        exp_unit();
        drain(4);
        compare("B");
        check("B_no_err", 32'(err_pulses), 32'(0));

        // C: doubled message -> doubled parity
        send_beat(8'h00, 1'b0);
        send_beat(8'h02, 1'b1);
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'h02, 1'b0, 1'b0);
        push_exp(8'h9B, 1'b1, 1'b0);
        push_exp(8'h3E, 1'b1, 1'b1);
        drain(4);
        compare("C");

        // D: four codewords under random back-pressure
        rand_rdy = 1'b1;
        repeat (4) begin
            send_unit();
            exp_unit();
        end
        drain(16);
        compare("D");
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        tick();

        // E: four codewords, no back-pressure, must stream without bubbles
        repeat (4) begin
            send_unit();
            exp_unit();
        end
        drain(16);
        span = (got_cyc.size() >= 16) ? (got_cyc[15] - got_cyc[0]) : -1;
        check("E_span", 32'(span), 32'(15));
        compare("E");

        // F: over-length message; beat 5 is forced last, beat 6 opens the next codeword
        err_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(8'h00, 1'b0);
            push_exp(8'h00, 1'b0, 1'b0);
        end
        send_beat(8'h02, 1'b0);
        send_beat(8'h00, 1'b0);
        send_beat(8'h01, 1'b1);
        push_exp(8'h02, 1'b0, 1'b0);
        push_exp(8'h9B, 1'b1, 1'b0);
        push_exp(8'h3E, 1'b1, 1'b1);
        exp_unit();
        drain(11);
        check("F_err_count", 32'(err_pulses), 32'(1));
        check("F_err_beat",  32'(err_idx),    32'(4));
        compare("F");

        // G: reset during the first parity beat
        send_unit();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("G_par_before_rst", 32'(out_parity), 32'(1));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("G_rst_out_valid",  32'(out_valid),  32'(0));
        check("G_rst_out_data",   32'(out_data),   32'(0));
        check("G_rst_out_parity", 32'(out_parity), 32'(0));
        check("G_rst_out_last",   32'(out_last),   32'(0));
        check("G_rst_in_ready",   32'(in_ready),   32'(1));
        tick();
        got_q.delete();
        got_cyc.delete();
        send_unit();
        exp_unit();
        drain(4);
        compare("G");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
